membus_fabric: RTL and testbench

- Parametrised memory-bus interconnect between one KA10 processor membus port and NMEM core memory modules (core161c-class).
- Supersedes the fixed single-module wiring with three additions: sel-decoded per-module request steering, per-cycle channel latching, and non-existent-memory (NXM) detection by decode miss or address-acknowledge timeout.
- Sits between ka10 and the memory modules in the top-level system.

---
 rtl/membus_fabric.sv | 183 ++++++++++++++++++
 tb/tb_membus_fabric.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_fabric.sv
// KA10 memory-bus fabric: steers one processor request to the core module whose select code
// matches ma[18:21], forwards the handshake pulses, and raises NXM on decode miss or timeout.
module membus_fabric #(
    parameter int unsigned NMEM    = 4,
    parameter logic [63:0] MEMSEL  = 64'h0000_0000_0000_3210,
    parameter int unsigned TIMEOUT = 100,
    parameter int unsigned TMO_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 membus_rq_cyc,
    input  logic                 membus_rd_rq,
    input  logic                 membus_wr_rq,
    input  logic                 membus_wr_rs,
    input  logic [18:35]         membus_ma,
    input  logic                 membus_fmc_select,
    input  logic [0:35]          membus_mb_out,
    output logic                 membus_addr_ack,
    output logic                 membus_rd_rs,
    output logic [0:35]          membus_mb_in,
    output logic                 membus_nxm,
    output logic [NMEM-1:0]      mem_rq_cyc,
    output logic [NMEM-1:0]      mem_rd_rq,
    output logic [NMEM-1:0]      mem_wr_rq,
    output logic [NMEM-1:0]      mem_wr_rs,
    input  logic [NMEM-1:0]      mem_addr_ack,
    input  logic [NMEM-1:0]      mem_rd_rs,
    input  logic [36*NMEM-1:0]   mem_mb_out,
    output logic [0:35]          mem_mb_in
);

    typedef enum logic [2:0] {StIdle, StAck, StRs, StNxm, StDone} state_t;

    state_t             r_state, w_state_d;
    logic [3:0]         r_ch, w_ch_d;
    logic               r_rd, w_rd_d;
    logic               r_wr, w_wr_d;
    logic               r_rd_done, w_rd_done_d;
    logic [TMO_W-1:0]   r_cnt, w_cnt_d;
    logic               r_nxm;

    logic               w_hit;
    logic [3:0]         w_idx;
    logic [NMEM-1:0]    w_oh;
    logic               w_ack;
    logic               w_rdrs;
    logic               w_tmo;
    logic [35:0]        w_ch_data;
    logic               w_unused_ma;

    assign w_unused_ma = ^membus_ma[22:35];
    assign w_oh        = NMEM'(1) << r_ch;
    assign w_ack       = |(mem_addr_ack & w_oh);
    assign w_rdrs      = |(mem_rd_rs & w_oh);
    assign w_tmo       = (r_cnt >= TMO_W'(TIMEOUT - 1));
    assign mem_mb_in   = membus_mb_out;

    // Descending scan so the lowest matching channel is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = int'(NMEM) - 1; i >= 0; i--) begin
            if (MEMSEL[4*i +: 4] == membus_ma[18:21]) begin
                w_hit = 1'b1;
                w_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_ch_data = '0;
        for (int i = 0; i < int'(NMEM); i++) begin
            if (r_ch == 4'(i)) w_ch_data = mem_mb_out[36*i +: 36];
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_ch_d      = r_ch;
        w_rd_d      = r_rd;
        w_wr_d      = r_wr;
        w_rd_done_d = r_rd_done;
        w_cnt_d     = r_cnt;
        case (r_state)
            StIdle: begin
                if (membus_rq_cyc && !membus_fmc_select) begin
                    if (w_hit) begin
                        w_ch_d      = w_idx;
                        w_rd_d      = membus_rd_rq;
                        w_wr_d      = membus_wr_rq;
                        w_rd_done_d = 1'b0;
                        w_cnt_d     = '0;
                        w_state_d   = StAck;
                    end else begin
                        w_state_d = StNxm;
                    end
                end
            end
            StAck: begin
                w_cnt_d = (&r_cnt) ? r_cnt : r_cnt + TMO_W'(1);
                if (!membus_rq_cyc)  w_state_d = StIdle;
                else if (w_ack)      w_state_d = StRs;
                else if (w_tmo)      w_state_d = StNxm;
            end
            StRs: begin
                if (r_rd && !r_rd_done) begin
                    if (w_rdrs) begin
                        if (r_wr) w_rd_done_d = 1'b1;
                        else      w_state_d   = StDone;
                    end
                end else if (r_wr) begin
                    if (membus_wr_rs) w_state_d = StDone;
                end else begin
                    w_state_d = StDone;
                end
            end
            StNxm: begin
                // Drop the latched direction so DONE does not merge stale module data.
                w_rd_d    = 1'b0;
                w_wr_d    = 1'b0;
                w_state_d = StDone;
            end
            StDone: begin
                if (!membus_rq_cyc) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_ch      <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_rd_done <= 1'b0;
            r_cnt     <= '0;
            r_nxm     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_ch      <= w_ch_d;
            r_rd      <= w_rd_d;
            r_wr      <= w_wr_d;
            r_rd_done <= w_rd_done_d;
            r_cnt     <= w_cnt_d;
            r_nxm     <= (r_state == StNxm);
        end
    end

    // All processor-facing outputs are gated by reset so an abandoned cycle emits nothing.
    always_comb begin
        membus_addr_ack = 1'b0;
        membus_rd_rs    = 1'b0;
        membus_mb_in    = membus_mb_out;
        membus_nxm      = r_nxm & ~reset;
        mem_rq_cyc      = '0;
        mem_rd_rq       = '0;
        mem_wr_rq       = '0;
        mem_wr_rs       = '0;
        if (reset) begin
            membus_mb_in = '0;
        end else begin
            case (r_state)
                StAck: begin
                    mem_rq_cyc      = w_oh & {NMEM{membus_rq_cyc}};
                    mem_rd_rq       = w_oh & {NMEM{membus_rd_rq}};
                    mem_wr_rq       = w_oh & {NMEM{membus_wr_rq}};
                    membus_addr_ack = w_ack & membus_rq_cyc;
                end
                StRs: begin
                    if (r_rd && !r_rd_done) membus_rd_rs = w_rdrs;
                    if (r_wr && (!r_rd || r_rd_done)) mem_wr_rs = w_oh & {NMEM{membus_wr_rs}};
                    if (r_rd) membus_mb_in = membus_mb_out | w_ch_data;
                end
                StDone: begin
                    if (r_rd) membus_mb_in = membus_mb_out | w_ch_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_membus_fabric.sv
// Scoreboard bench for membus_fabric: a processor/memory driver pushes expected pulses with
// their cycle numbers; a negedge monitor pops and compares whenever the fabric emits one.
module tb_membus_fabric;

    localparam int unsigned NMEM    = 4;
    localparam logic [63:0] MEMSEL  = 64'h0000_0000_0007_3210;
    localparam int unsigned TIMEOUT = 10;
    localparam int unsigned TMO_W   = 8;
    localparam int EvAck = 0, EvRd = 1, EvWr = 2, EvNxm = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs;
    logic [18:35]        membus_ma;
    logic                membus_fmc_select;
    logic [0:35]         membus_mb_out;
    logic                membus_addr_ack, membus_rd_rs, membus_nxm;
    logic [0:35]         membus_mb_in;
    logic [NMEM-1:0]     mem_rq_cyc, mem_rd_rq, mem_wr_rq, mem_wr_rs;
    logic [NMEM-1:0]     mem_addr_ack, mem_rd_rs;
    logic [36*NMEM-1:0]  mem_mb_out;
    logic [0:35]         mem_mb_in;

    typedef struct {
        int          kind;
        longint      cyc;
        logic [35:0] val;
    } ev_t;

    ev_t             exp_q[$];
    int              total = 0;
    int              bad = 0;
    longint          cyc = 0;
    logic [NMEM-1:0] exp_rq, exp_rdm, exp_wrm;
    bit              exp_zero, mbin_chk, mon_en;

    membus_fabric #(
        .NMEM(NMEM), .MEMSEL(MEMSEL), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .reset(reset),
        .membus_rq_cyc(membus_rq_cyc), .membus_rd_rq(membus_rd_rq),
        .membus_wr_rq(membus_wr_rq), .membus_wr_rs(membus_wr_rs),
        .membus_ma(membus_ma), .membus_fmc_select(membus_fmc_select),
        .membus_mb_out(membus_mb_out), .membus_addr_ack(membus_addr_ack),
        .membus_rd_rs(membus_rd_rs), .membus_mb_in(membus_mb_in), .membus_nxm(membus_nxm),
        .mem_rq_cyc(mem_rq_cyc), .mem_rd_rq(mem_rd_rq), .mem_wr_rq(mem_wr_rq),
        .mem_wr_rs(mem_wr_rs), .mem_addr_ack(mem_addr_ack), .mem_rd_rs(mem_rd_rs),
        .mem_mb_out(mem_mb_out), .mem_mb_in(mem_mb_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic pop_ev(input int kind, input logic [35:0] val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got kind=%0d at cycle %0d want none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
                bad++;
                $display("FAIL event: got kind=%0d cyc=%0d val=%0o want kind=%0d cyc=%0d val=%0o",
                         kind, cyc, val, e.kind, e.cyc, e.val);
            end
        end
    endtask

    task automatic push(input int kind, input longint c, input logic [35:0] v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Reference decode: the first channel below NMEM whose select code equals sel.
    function automatic int model_ch(input logic [3:0] sel);
        logic [63:0] ms;
        ms = MEMSEL;
        for (int i = 0; i < int'(NMEM); i++) if (ms[4*i +: 4] == sel) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("mem_mb_in", 64'(mem_mb_in), 64'(membus_mb_out));
            if (exp_zero) begin
                check("reset_outputs", 64'({membus_addr_ack, membus_rd_rs, membus_nxm, mem_rq_cyc,
                      mem_rd_rq, mem_wr_rq, mem_wr_rs, membus_mb_in}), 64'(0));
            end else begin
                check("steer", 64'({mem_rq_cyc, mem_rd_rq, mem_wr_rq}),
                      64'({exp_rq, exp_rdm, exp_wrm}));
                if (mbin_chk) check("mb_in_pass", 64'(membus_mb_in), 64'(membus_mb_out));
                if (membus_addr_ack) pop_ev(EvAck, '0);
                if (membus_rd_rs)    pop_ev(EvRd, membus_mb_in);
                if (|mem_wr_rs)      pop_ev(EvWr, 36'(mem_wr_rs));
                if (membus_nxm)      pop_ev(EvNxm, '0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [3:0] sel, input bit rd, input bit wr, input bit fmc,
                       input int ack_dly, input int rs_dly, input int wr_dly,
                       input logic [35:0] data, input logic [35:0] wdat, input bit rst_rs);
        int              ch;
        logic [NMEM-1:0] oh;
        longint          c0;
        bit              acked;
        ch = fmc ? -1 : model_ch(sel);
        oh = (ch >= 0) ? NMEM'(1) << ch : '0;
        for (int i = 0; i < int'(NMEM); i++) mem_mb_out[36*i +: 36] = 36'({$urandom, $urandom});
        if (ch >= 0) mem_mb_out[36*ch +: 36] = data;
        step();
        membus_ma         = {sel, 14'($urandom)};
        membus_rd_rq      = rd;
        membus_wr_rq      = wr;
        membus_fmc_select = fmc;
        membus_mb_out     = wdat;
        membus_rq_cyc     = 1'b1;
        c0 = cyc;
        if (fmc) begin
            mbin_chk = 1'b1;
            repeat (5) step();
            mbin_chk = 1'b0;
        end else if (ch < 0) begin
            push(EvNxm, c0 + 2, '0);
            repeat (6) step();
        end else begin
            acked = 1'b0;
            if (ack_dly >= int'(TIMEOUT)) push(EvNxm, c0 + TIMEOUT + 2, '0);
            for (int n = 1; n <= int'(TIMEOUT) + 3 && !acked; n++) begin
                step();
                mem_addr_ack = '0;
                exp_rq = '0; exp_rdm = '0; exp_wrm = '0;
                if (n <= int'(TIMEOUT)) begin
                    exp_rq       = oh;
                    exp_rdm      = rd ? oh : '0;
                    exp_wrm      = wr ? oh : '0;
                    mem_addr_ack = NMEM'($urandom) & ~oh;
                end
                if (n == ack_dly + 1) begin
                    mem_addr_ack = mem_addr_ack | oh;
                    if (n <= int'(TIMEOUT)) begin
                        push(EvAck, cyc, '0);
                        acked = 1'b1;
                    end
                end
            end
            step();
            mem_addr_ack = '0;
            exp_rq = '0; exp_rdm = '0; exp_wrm = '0;
            if (acked) begin
                if (rd) begin
                    mem_rd_rs = NMEM'($urandom) & ~oh;
                    repeat (rs_dly) begin
                        step();
                        mem_rd_rs = NMEM'($urandom) & ~oh;
                    end
                    if (rst_rs) begin
                        reset = 1'b1;
                        membus_rq_cyc = 1'b0; membus_rd_rq = 1'b0; membus_wr_rq = 1'b0;
                        membus_mb_out = 36'({$urandom, $urandom});
                        mem_rd_rs = oh;
                        exp_zero = 1'b1;
                        step();
                        reset = 1'b0;
                        mem_rd_rs = '0;
                        membus_mb_out = '0;
                        step();
                        exp_zero = 1'b0;
                        return;
                    end
                    mem_rd_rs = oh;
                    push(EvRd, cyc, wdat | data);
                    step();
                    mem_rd_rs = '0;
                end
                if (wr) begin
                    repeat (wr_dly) step();
                    membus_wr_rs = 1'b1;
                    push(EvWr, cyc, 36'(oh));
                    step();
                    membus_wr_rs = 1'b0;
                end
            end
            repeat (2) step();
        end
        membus_rq_cyc = 1'b0; membus_rd_rq = 1'b0; membus_wr_rq = 1'b0;
        membus_fmc_select = 1'b0; mem_addr_ack = '0; mem_rd_rs = '0;
        repeat (2) step();
    endtask

    initial begin
        int op;
        reset = 1'b1;
        membus_rq_cyc = 1'b0; membus_rd_rq = 1'b0; membus_wr_rq = 1'b0; membus_wr_rs = 1'b0;
        membus_ma = '0; membus_fmc_select = 1'b0;
        membus_mb_out = 36'({$urandom, $urandom});
        mem_addr_ack = '0; mem_rd_rs = '0; mem_mb_out = '0;
        exp_rq = '0; exp_rdm = '0; exp_wrm = '0;
        exp_zero = 1'b1; mbin_chk = 1'b0; mon_en = 1'b0;
        step();
        mon_en = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        membus_mb_out = '0;
        step();
        exp_zero = 1'b0;

        txn(4'd2, 1, 0, 0, 2, 2, 0, 36'o123456654321, 36'o0, 0);
        txn(4'd0, 0, 1, 0, 1, 0, 1, 36'o0, 36'o777000000777, 0);
        txn(4'd7, 1, 0, 0, 0, 0, 0, 36'o1, 36'o2, 0);
        txn(4'd4, 0, 1, 0, 0, 0, 0, 36'o1, 36'o2, 0);
        txn(4'd1, 1, 0, 0, TIMEOUT, 0, 0, 36'o55, 36'o0, 0);
        txn(4'd1, 0, 1, 0, TIMEOUT - 1, 0, 0, 36'o0, 36'o707070707070, 0);
        txn(4'd2, 1, 0, 0, 1, 1, 0, 36'o4444, 36'o0, 1);
        txn(4'd3, 1, 0, 0, 0, 0, 0, 36'o765432101234, 36'o0, 0);
        txn(4'd0, 1, 0, 1, 0, 0, 0, 36'o1, 36'o000000000005, 0);
        txn(4'd3, 1, 1, 0, 2, 1, 1, 36'o111222333444, 36'o000000000017, 0);

        for (int k = 0; k < 60; k++) begin
            op = int'($urandom_range(0, 2));
            txn(4'($urandom_range(0, 8)), op != 1, op != 0, $urandom_range(0, 9) == 0,
                int'($urandom_range(0, TIMEOUT + 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 36'({$urandom, $urandom}),
                36'({$urandom, $urandom}), $urandom_range(0, 15) == 0);
        end

        repeat (3) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
